char_rom_scheduler: RTL and testbench

//   Shares one synchronous character ROM (1-cycle read latency) among all display digits.
//   On a load request it fetches one glyph per digit back-to-back into a shadow buffer.
//   It then commits the full frame atomically onto the segment bus that feeds scan_unit.

---
 rtl/char_rom_scheduler_if.sv | 25 ++
 rtl/char_rom_scheduler.sv | 129 ++++++++++++
 tb/tb_char_rom_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/char_rom_scheduler_if.sv
// rtl/char_rom_scheduler_if.sv - load/ROM/segment-bus signal bundle for char_rom_scheduler
interface char_rom_scheduler_if #(
    parameter int NUM_DIGITS = 4,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8
);
    logic                         load;
    logic [NUM_DIGITS*ADDR_W-1:0] addr_in;
    logic                         rom_en;
    logic [ADDR_W-1:0]            rom_addr;
    logic [DATA_W-1:0]            rom_data;
    logic [NUM_DIGITS*DATA_W-1:0] sseg_bus;
    logic                         busy;
    logic                         done;

    modport master (
        output load, addr_in, rom_data,
        input  rom_en, rom_addr, sseg_bus, busy, done
    );

    modport slave (
        input  load, addr_in, rom_data,
        output rom_en, rom_addr, sseg_bus, busy, done
    );
endinterface

// File: rtl/char_rom_scheduler.sv
// rtl/char_rom_scheduler.sv - shares one character ROM across all digits, commits frames atomically
module char_rom_scheduler #(
    parameter int                NUM_DIGITS = 4,
    parameter int                ADDR_W     = 5,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] BLANK      = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst,
    char_rom_scheduler_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int LAST  = NUM_DIGITS - 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [IDX_W-1:0]             cap_idx_q, cap_idx_d;
    logic                         cap_valid_q, cap_valid_d;
    logic [NUM_DIGITS*ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [NUM_DIGITS*ADDR_W-1:0] pending_addr_q, pending_addr_d;
    logic                         pending_q, pending_d;
    logic [DATA_W-1:0]            shadow_q [NUM_DIGITS];
    logic [DATA_W-1:0]            shadow_d [NUM_DIGITS];
    logic [NUM_DIGITS*DATA_W-1:0] sseg_q, sseg_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [ADDR_W-1:0]            digit_addr;

    always_comb begin
        digit_addr = addr_hold_q[(LAST - int'(idx_q))*ADDR_W +: ADDR_W];
    end

    assign bus.rom_en   = (state_q == FETCH);
    assign bus.rom_addr = (state_q == FETCH) ? digit_addr : '0;
    assign bus.sseg_bus = sseg_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        addr_hold_d    = addr_hold_q;
        pending_d      = pending_q;
        pending_addr_d = pending_addr_q;
        cap_valid_d    = (state_q == FETCH);
        cap_idx_d      = idx_q;
        shadow_d       = shadow_q;
        sseg_d         = sseg_q;
        done_d         = 1'b0;

        // ROM data lags the issued address by one cycle
        if (cap_valid_q) begin
            shadow_d[cap_idx_q] = bus.rom_data;
        end

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    addr_hold_d = bus.addr_in;
                    idx_d       = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                idx_d = idx_q + IDX_W'(1);
                if (bus.load) begin
                    pending_addr_d = bus.addr_in;
                    pending_d      = 1'b1;
                end
                if (idx_q == IDX_W'(LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Commit includes the last digit captured this very cycle
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    sseg_d[(LAST - i)*DATA_W +: DATA_W] = shadow_d[i];
                end
                done_d    = 1'b1;
                pending_d = 1'b0;
                idx_d     = '0;
                if (bus.load) begin
                    addr_hold_d = bus.addr_in;
                    state_d     = FETCH;
                end else if (pending_q) begin
                    addr_hold_d = pending_addr_q;
                    state_d     = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            cap_idx_q      <= '0;
            cap_valid_q    <= 1'b0;
            addr_hold_q    <= '0;
            pending_addr_q <= '0;
            pending_q      <= 1'b0;
            sseg_q         <= {NUM_DIGITS{BLANK}};
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cap_idx_q      <= cap_idx_d;
            cap_valid_q    <= cap_valid_d;
            addr_hold_q    <= addr_hold_d;
            pending_addr_q <= pending_addr_d;
            pending_q      <= pending_d;
            sseg_q         <= sseg_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end
endmodule

// File: tb/tb_char_rom_scheduler.sv
// tb/tb_char_rom_scheduler.sv - directed self-checking bench for char_rom_scheduler
module tb_char_rom_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    char_rom_scheduler_if #(.NUM_DIGITS(4), .ADDR_W(5), .DATA_W(8)) bus ();

    char_rom_scheduler #(
        .NUM_DIGITS(4), .ADDR_W(5), .DATA_W(8), .BLANK(8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= {3'b010, bus.rom_addr};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    localparam logic [19:0] A_T2 = {5'd22, 5'd16, 5'd27, 5'd29};
    localparam logic [19:0] A_A  = {5'd0,  5'd1,  5'd2,  5'd3};
    localparam logic [19:0] A_B  = {5'd4,  5'd5,  5'd6,  5'd7};
    localparam logic [19:0] A_C  = {5'd8,  5'd9,  5'd10, 5'd11};
    localparam logic [19:0] A_D  = {5'd12, 5'd13, 5'd14, 5'd15};
    localparam logic [19:0] A_E  = {5'd16, 5'd17, 5'd18, 5'd19};
    localparam logic [19:0] A_F  = {5'd20, 5'd21, 5'd22, 5'd23};
    localparam logic [19:0] A_G  = {5'd24, 5'd25, 5'd26, 5'd27};
    localparam logic [19:0] A_H  = {5'd28, 5'd29, 5'd30, 5'd31};

    logic [4:0] t2_addrs [4] = '{5'd22, 5'd16, 5'd27, 5'd29};

    task automatic idle(input int n);
        bus.load = 1'b0;
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.addr_in  = '0;
        bus.rom_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state and quiet idle
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("t1_sseg",   bus.sseg_bus, 32'hFFFF_FFFF);
            check("t1_busy",   {31'd0, bus.busy},   32'd0);
            check("t1_done",   {31'd0, bus.done},   32'd0);
            check("t1_rom_en", {31'd0, bus.rom_en}, 32'd0);
        end
        check("t1_rom_addr", {27'd0, bus.rom_addr}, 32'd0);

        // 2: single frame, latency and address order
        bus.load = 1'b1; bus.addr_in = A_T2;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            bus.load = 1'b0; bus.addr_in = '0;
            if (c <= 4) begin
                check("t2_rom_en",   {31'd0, bus.rom_en}, 32'd1);
                check("t2_rom_addr", {27'd0, bus.rom_addr}, {27'd0, t2_addrs[c-1]});
            end
            if (c <= 5) begin
                check("t2_busy",      {31'd0, bus.busy}, 32'd1);
                check("t2_no_tear",   bus.sseg_bus, 32'hFFFF_FFFF);
                check("t2_done_early", {31'd0, bus.done}, 32'd0);
            end
            if (c == 5) check("t2_drain_rom_en", {31'd0, bus.rom_en}, 32'd0);
            if (c == 6) begin
                check("t2_sseg", bus.sseg_bus, 32'h5650_5B5D);
                check("t2_done", {31'd0, bus.done}, 32'd1);
                check("t2_busy_end", {31'd0, bus.busy}, 32'd0);
            end
            if (c == 7) check("t2_done_once", {31'd0, bus.done}, 32'd0);
        end
        idle(3);

        // 3: loads while busy, latest pending wins
        bus.load = 1'b1; bus.addr_in = A_A;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus.load    = (c == 2) || (c == 3);
            bus.addr_in = (c == 2) ? A_B : (c == 3) ? A_C : '0;
            if (c <= 10) check("t3_busy", {31'd0, bus.busy}, 32'd1);
            check("t3_no_b", {31'd0, bus.sseg_bus == 32'h4445_4647}, 32'd0);
            if (c == 6) begin
                check("t3_sseg_a", bus.sseg_bus, 32'h4041_4243);
                check("t3_done_a", {31'd0, bus.done}, 32'd1);
                check("t3_c_addr", {27'd0, bus.rom_addr}, 32'd8);
            end
            if (c == 11) begin
                check("t3_sseg_c", bus.sseg_bus, 32'h4849_4A4B);
                check("t3_done_c", {31'd0, bus.done}, 32'd1);
                check("t3_idle",   {31'd0, bus.busy}, 32'd0);
            end
            if (c == 12) check("t3_done_once", {31'd0, bus.done}, 32'd0);
        end
        idle(3);

        // 4: load coinciding with the DRAIN cycle
        bus.load = 1'b1; bus.addr_in = A_D;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus.load    = (c == 5);
            bus.addr_in = (c == 5) ? A_E : '0;
            if (c <= 10) check("t4_busy", {31'd0, bus.busy}, 32'd1);
            if (c == 6) begin
                check("t4_sseg_d",  bus.sseg_bus, 32'h4C4D_4E4F);
                check("t4_done_d",  {31'd0, bus.done}, 32'd1);
                check("t4_rom_en",  {31'd0, bus.rom_en}, 32'd1);
                check("t4_rom_addr", {27'd0, bus.rom_addr}, 32'd16);
            end
            if (c == 7) check("t4_done_once", {31'd0, bus.done}, 32'd0);
            if (c == 11) begin
                check("t4_sseg_e", bus.sseg_bus, 32'h5051_5253);
                check("t4_done_e", {31'd0, bus.done}, 32'd1);
            end
        end
        idle(3);

        // 5: reset in the middle of a fetch
        bus.load = 1'b1; bus.addr_in = A_F;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus.load = 1'b0; bus.addr_in = '0;
            rst = (c == 3);
            if (c == 4) begin
                check("t5_sseg",   bus.sseg_bus, 32'hFFFF_FFFF);
                check("t5_busy",   {31'd0, bus.busy},   32'd0);
                check("t5_rom_en", {31'd0, bus.rom_en}, 32'd0);
            end
            if (c >= 4) check("t5_no_done", {31'd0, bus.done}, 32'd0);
        end
        bus.load = 1'b1; bus.addr_in = A_G;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.load = 1'b0; bus.addr_in = '0;
            if (c == 6) begin
                check("t5_sseg_g", bus.sseg_bus, 32'h5859_5A5B);
                check("t5_done_g", {31'd0, bus.done}, 32'd1);
            end
        end
        idle(3);

        // 6: load held high, back-to-back frames
        bus.load = 1'b1; bus.addr_in = A_H;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            check("t6_busy", {31'd0, bus.busy}, 32'd1);
            check("t6_done", {31'd0, bus.done},
                  {31'd0, (c >= 6) && ((c - 6) % 5 == 0)});
            if (c == 6) check("t6_sseg", bus.sseg_bus, 32'h5C5D_5E5F);
        end
        bus.load = 1'b0; bus.addr_in = '0;
        idle(12);
        check("t6_final_idle", {31'd0, bus.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
